// File: rtl/map_pkg.sv
// Shared types and default sizes for the rename map table and its checkpoint controller.
package map_pkg;

    localparam int N_WAY_DEF     = 2;
    localparam int ARCH_REGS_DEF = 32;
    localparam int PREG_BITS_DEF = 6;
    localparam int N_CKPT_DEF    = 4;

    // One map-table entry: physical tag plus "value is ready" flag.
    typedef struct packed {
        logic [PREG_BITS_DEF-1:0] phy_reg;
        logic                     status;
    } PR_PACKET;

endpackage

// File: rtl/map_ckpt_ctrl.sv
// Circular-buffer bookkeeping (head/tail/count/valid) for map-table checkpoint slots.
module map_ckpt_ctrl
    import map_pkg::*;
#(
    parameter int N_CKPT    = N_CKPT_DEF,
    parameter int CKPT_BITS = $clog2(N_CKPT)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alloc,
    input  logic                 br_valid,
    input  logic                 br_mispred,
    input  logic [CKPT_BITS-1:0] br_id,
    output logic [CKPT_BITS-1:0] tail,
    output logic                 full
);

    logic [CKPT_BITS-1:0] head_q, head_d;
    logic [CKPT_BITS-1:0] tail_q, tail_d;
    logic [CKPT_BITS:0]   count_q, count_d;
    logic [N_CKPT-1:0]    valid_q, valid_d;
    logic [CKPT_BITS-1:0] br_off;
    logic [CKPT_BITS-1:0] slot_off;

    // Resolve/flush first, then reclaim one dead slot at head, then allocate at tail.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid_d  = valid_q;
        br_off   = br_id - head_q;
        slot_off = '0;

        if (br_valid && !br_mispred) begin
            valid_d[br_id] = 1'b0;
        end

        if (br_valid && br_mispred) begin
            for (int j = 0; j < N_CKPT; j++) begin
                slot_off = CKPT_BITS'(j) - head_q;
                if (slot_off >= br_off) begin
                    valid_d[j] = 1'b0;
                end
            end
            tail_d  = br_id + 1'b1;
            count_d = {1'b0, br_off} + 1'b1;
        end

        if ((count_d != '0) && !valid_d[head_q]) begin
            head_d  = head_q + 1'b1;
            count_d = count_d - 1'b1;
        end

        if (alloc) begin
            valid_d[tail_d] = 1'b1;
            tail_d          = tail_d + 1'b1;
            count_d         = count_d + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign tail = tail_q;
    assign full = (count_q == (CKPT_BITS+1)'(N_CKPT));

    no_alloc_when_full: assert property (@(posedge clock) disable iff (!reset_n) !(alloc && full));

endmodule

// File: rtl/map_table_ckpt.sv
// Register rename map table with CDB wakeup and intra-bundle forwarding.
// Define MAP_TABLE_CKPT_EN to add branch checkpoints with mispredict recovery.
module map_table_ckpt
    import map_pkg::*;
#(
    parameter int N_WAY     = N_WAY_DEF,
    parameter int ARCH_REGS = ARCH_REGS_DEF,
    parameter int AREG_BITS = $clog2(ARCH_REGS),
    parameter int PREG_BITS = PREG_BITS_DEF,
    parameter int N_CKPT    = N_CKPT_DEF,
    parameter int CKPT_BITS = $clog2(N_CKPT)
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [N_WAY-1:0]                     dis_valid,
    input  logic [N_WAY-1:0][AREG_BITS-1:0]      dis_dest,
    input  logic [N_WAY-1:0][AREG_BITS-1:0]      dis_src1,
    input  logic [N_WAY-1:0][AREG_BITS-1:0]      dis_src2,
    input  logic [N_WAY-1:0][PREG_BITS-1:0]      dis_pr_new,
    input  logic [N_WAY-1:0]                     dis_br,
    input  logic [N_WAY-1:0]                     cdb_valid,
    input  logic [N_WAY-1:0][PREG_BITS-1:0]      cdb_tag,
    output PR_PACKET [N_WAY-1:0]                 src1_out,
    output PR_PACKET [N_WAY-1:0]                 src2_out,
    output logic [N_WAY-1:0][PREG_BITS-1:0]      told_out,
    output logic [CKPT_BITS-1:0]                 ckpt_id,
    output logic                                 ckpt_full,
    input  logic                                 br_valid,
    input  logic [CKPT_BITS-1:0]                 br_id,
    input  logic                                 br_mispred
);

    PR_PACKET         map_q    [ARCH_REGS];
    PR_PACKET         map_d    [ARCH_REGS];
    PR_PACKET         map_next [ARCH_REGS];
    logic [N_WAY-1:0] rename_en;

    function automatic logic tag_done(input logic [PREG_BITS-1:0]            tag,
                                      input logic [N_WAY-1:0]                cv,
                                      input logic [N_WAY-1:0][PREG_BITS-1:0] ct);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < N_WAY; c++) begin
            if (cv[c] && (ct[c] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        for (int n = 0; n < N_WAY; n++) begin
            rename_en[n] = dis_valid[n] && (dis_dest[n] != '0);
        end
    end

    // Source lookup: table plus CDB bypass, overridden by older ways of the same bundle.
    always_comb begin
        for (int n = 0; n < N_WAY; n++) begin
            src1_out[n]        = map_q[dis_src1[n]];
            src1_out[n].status = map_q[dis_src1[n]].status
                               | tag_done(map_q[dis_src1[n]].phy_reg, cdb_valid, cdb_tag);
            src2_out[n]        = map_q[dis_src2[n]];
            src2_out[n].status = map_q[dis_src2[n]].status
                               | tag_done(map_q[dis_src2[n]].phy_reg, cdb_valid, cdb_tag);
            told_out[n]        = map_q[dis_dest[n]].phy_reg;
            for (int k = 0; k < N_WAY; k++) begin
                if ((k < n) && rename_en[k]) begin
                    if (dis_dest[k] == dis_src1[n]) begin
                        src1_out[n] = '{phy_reg: dis_pr_new[k], status: 1'b0};
                    end
                    if (dis_dest[k] == dis_src2[n]) begin
                        src2_out[n] = '{phy_reg: dis_pr_new[k], status: 1'b0};
                    end
                    if (dis_dest[k] == dis_dest[n]) begin
                        told_out[n] = dis_pr_new[k];
                    end
                end
            end
        end
    end

    // Table after this cycle's completions and renames; later ways overwrite earlier ones.
    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            map_d[i]        = map_q[i];
            map_d[i].status = map_q[i].status | tag_done(map_q[i].phy_reg, cdb_valid, cdb_tag);
        end
        for (int n = 0; n < N_WAY; n++) begin
            if (rename_en[n]) begin
                map_d[dis_dest[n]] = '{phy_reg: dis_pr_new[n], status: 1'b0};
            end
        end
    end

`ifdef MAP_TABLE_CKPT_EN
    PR_PACKET             ckpt_q [N_CKPT][ARCH_REGS];
    PR_PACKET             ckpt_d [N_CKPT][ARCH_REGS];
    logic                 mispredict;
    logic                 alloc;
    logic [CKPT_BITS-1:0] tail;

    assign mispredict = br_valid && br_mispred;
    assign alloc      = (|(dis_valid & dis_br)) && !mispredict;

    map_ckpt_ctrl #(
        .N_CKPT    (N_CKPT),
        .CKPT_BITS (CKPT_BITS)
    ) u_ctrl (
        .clock      (clock),
        .reset_n    (reset_n),
        .alloc      (alloc),
        .br_valid   (br_valid),
        .br_mispred (br_mispred),
        .br_id      (br_id),
        .tail       (tail),
        .full       (ckpt_full)
    );

    assign ckpt_id = tail;

    // Snapshots keep waking up on the CDB so a restore never brings back stale "not ready" bits.
    always_comb begin
        for (int s = 0; s < N_CKPT; s++) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                ckpt_d[s][i]        = ckpt_q[s][i];
                ckpt_d[s][i].status = ckpt_q[s][i].status
                                    | tag_done(ckpt_q[s][i].phy_reg, cdb_valid, cdb_tag);
                if (alloc && (tail == CKPT_BITS'(s))) begin
                    ckpt_d[s][i] = map_d[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            map_next[i] = mispredict ? ckpt_d[br_id][i] : map_d[i];
        end
    end

    always_ff @(posedge clock) begin
        ckpt_q <= ckpt_d;
    end
`else
    logic unused_ckpt_inputs;
    assign unused_ckpt_inputs = ^{dis_br, br_valid, br_id, br_mispred};
    assign ckpt_id            = '0;
    assign ckpt_full          = 1'b0;

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            map_next[i] = map_d[i];
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= '{phy_reg: PREG_BITS'(i), status: 1'b1};
            end
        end else begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= map_next[i];
            end
        end
    end

endmodule

// File: tb/tb_map_table_ckpt.sv
// Scoreboard bench for map_table_ckpt: random and directed dispatch checked against an array/queue model.
module tb_map_table_ckpt;
    import map_pkg::*;

    localparam int NW = 2;
    localparam int NR = 32;
    localparam int PB = 6;
    localparam int NC = 4;
    localparam int CB = 2;
    localparam int AB = 5;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [NW-1:0]          dis_valid, dis_br, cdb_valid;
    logic [NW-1:0][AB-1:0]  dis_dest, dis_src1, dis_src2;
    logic [NW-1:0][PB-1:0]  dis_pr_new, cdb_tag;
    PR_PACKET [NW-1:0]      src1_out, src2_out;
    logic [NW-1:0][PB-1:0]  told_out;
    logic [CB-1:0]          ckpt_id, br_id;
    logic                   ckpt_full, br_valid, br_mispred;

    always #5 clock = ~clock;

    map_table_ckpt dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .dis_valid  (dis_valid),
        .dis_dest   (dis_dest),
        .dis_src1   (dis_src1),
        .dis_src2   (dis_src2),
        .dis_pr_new (dis_pr_new),
        .dis_br     (dis_br),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .src1_out   (src1_out),
        .src2_out   (src2_out),
        .told_out   (told_out),
        .ckpt_id    (ckpt_id),
        .ckpt_full  (ckpt_full),
        .br_valid   (br_valid),
        .br_id      (br_id),
        .br_mispred (br_mispred)
    );

    // Reference state: architectural map as plain arrays, checkpoints as an age-ordered queue.
    int  ref_phy [NR];
    bit  ref_st  [NR];
    int  ck_phy  [NC][NR];
    bit  ck_st   [NC][NR];
    int  ck_ids  [$];
    bit  ck_res  [$];
    int  ref_tail;

    typedef struct packed {
        logic [NW-1:0][PB:0]   s1;
        logic [NW-1:0][PB:0]   s2;
        logic [NW-1:0][PB-1:0] told;
        logic [CB-1:0]         id;
        logic                  full;
    } exp_t;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic bit cdb_hit(input int tag);
        bit h;
        h = 1'b0;
        for (int c = 0; c < NW; c++) begin
            if (cdb_valid[c] && (int'(cdb_tag[c]) == tag)) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [PB:0] ref_lookup(input int n, input int r);
        logic [PB:0] res;
        res = {PB'(ref_phy[r]), ref_st[r] | cdb_hit(ref_phy[r])};
        for (int k = 0; k < n; k++) begin
            if (dis_valid[k] && (dis_dest[k] != 0) && (int'(dis_dest[k]) == r))
                res = {dis_pr_new[k], 1'b0};
        end
        return res;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            ref_phy[i] = i;
            ref_st[i]  = 1'b1;
        end
        ck_ids.delete();
        ck_res.delete();
        ref_tail = 0;
    endtask

    task automatic pushExpected();
        exp_t        e;
        logic [PB:0] t;
        for (int n = 0; n < NW; n++) begin
            e.s1[n]   = ref_lookup(n, int'(dis_src1[n]));
            e.s2[n]   = ref_lookup(n, int'(dis_src2[n]));
            t         = ref_lookup(n, int'(dis_dest[n]));
            e.told[n] = t[PB:1];
        end
`ifdef MAP_TABLE_CKPT_EN
        e.id   = CB'(ref_tail);
        e.full = (ck_ids.size() == NC);
`else
        e.id   = '0;
        e.full = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic modelStep();
        bit mis;
        int p;
        mis = 1'b0;
`ifdef MAP_TABLE_CKPT_EN
        mis = br_valid && br_mispred;
`endif
        for (int i = 0; i < NR; i++) begin
            if (cdb_hit(ref_phy[i])) ref_st[i] = 1'b1;
            for (int s = 0; s < NC; s++) begin
                if (cdb_hit(ck_phy[s][i])) ck_st[s][i] = 1'b1;
            end
        end
        if (mis) begin
            for (int i = 0; i < NR; i++) begin
                ref_phy[i] = ck_phy[br_id][i];
                ref_st[i]  = ck_st[br_id][i];
            end
        end else begin
            for (int n = 0; n < NW; n++) begin
                if (dis_valid[n] && dis_dest[n] != 0) begin
                    ref_phy[dis_dest[n]] = int'(dis_pr_new[n]);
                    ref_st[dis_dest[n]]  = 1'b0;
                end
            end
        end
`ifdef MAP_TABLE_CKPT_EN
        if (br_valid) begin
            p = -1;
            foreach (ck_ids[q]) if (ck_ids[q] == int'(br_id)) p = q;
            if (p >= 0) begin
                if (!mis) begin
                    ck_res[p] = 1'b1;
                end else begin
                    while (ck_ids.size() > p + 1) begin
                        void'(ck_ids.pop_back());
                        void'(ck_res.pop_back());
                    end
                    ck_res[p] = 1'b1;
                    ref_tail  = (int'(br_id) + 1) % NC;
                end
            end
        end
        if (ck_ids.size() > 0 && ck_res[0]) begin
            void'(ck_ids.pop_front());
            void'(ck_res.pop_front());
        end
        if (!mis && |(dis_valid & dis_br)) begin
            for (int i = 0; i < NR; i++) begin
                ck_phy[ref_tail][i] = ref_phy[i];
                ck_st[ref_tail][i]  = ref_st[i];
            end
            ck_ids.push_back(ref_tail);
            ck_res.push_back(1'b0);
            ref_tail = (ref_tail + 1) % NC;
        end
`endif
    endtask

    task automatic setIdle();
        dis_valid  = '0;
        dis_br     = '0;
        cdb_valid  = '0;
        br_valid   = 1'b0;
        br_mispred = 1'b0;
        br_id      = '0;
        for (int n = 0; n < NW; n++) begin
            dis_dest[n]   = AB'($urandom);
            dis_src1[n]   = AB'($urandom);
            dis_src2[n]   = AB'($urandom);
            dis_pr_new[n] = PB'($urandom);
            cdb_tag[n]    = PB'($urandom);
        end
    endtask

    task automatic applyStimulus();
        pushExpected();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    // Reset is asserted between edges and checked before any clock edge arrives.
    task automatic applyReset();
        reset_n = 1'b0;
        setIdle();
        dis_src1[0] = 5;
        modelReset();
        #1;
        pushExpected();
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic genRandom();
        int cand [$];
        setIdle();
        dis_valid = NW'($urandom_range(0, 3));
        for (int n = 0; n < NW; n++) begin
            if ($urandom_range(0, 7) == 0) dis_dest[n] = '0;
            if (n > 0 && $urandom_range(0, 2) == 0) dis_src1[n] = dis_dest[0];
            if (n > 0 && $urandom_range(0, 3) == 0) dis_src2[n] = dis_dest[0];
            if (n > 0 && $urandom_range(0, 5) == 0) dis_dest[n] = dis_dest[0];
            cdb_valid[n] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) cdb_tag[n] = PB'(ref_phy[$urandom_range(0, NR-1)]);
        end
`ifdef MAP_TABLE_CKPT_EN
        if (ck_ids.size() < NC && $urandom_range(0, 2) == 0) begin
            if (dis_valid[1])      dis_br = 2'b10;
            else if (dis_valid[0]) dis_br = 2'b01;
        end
        foreach (ck_ids[q]) if (!ck_res[q]) cand.push_back(ck_ids[q]);
        if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
            br_valid   = 1'b1;
            br_id      = CB'(cand[$urandom_range(0, cand.size() - 1)]);
            br_mispred = ($urandom_range(0, 3) == 0);
        end
`else
        dis_br     = NW'($urandom);
        br_valid   = 1'($urandom);
        br_id      = CB'($urandom);
        br_mispred = 1'($urandom);
`endif
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s[%0d] actual=%0h required=%0h at %0t", name, idx, actual, expected, $time);
        end
    endtask

    // Monitor: outputs are combinational, so every mid-cycle sample settles one queued expectation.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int n = 0; n < NW; n++) begin
                checkOutput("src1_out", n, 32'(src1_out[n]), 32'(e.s1[n]));
                checkOutput("src2_out", n, 32'(src2_out[n]), 32'(e.s2[n]));
                checkOutput("told_out", n, 32'(told_out[n]), 32'(e.told[n]));
            end
            checkOutput("ckpt_id", 0, 32'(ckpt_id), 32'(e.id));
            checkOutput("ckpt_full", 0, 32'(ckpt_full), 32'(e.full));
        end
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        reset_n = 1'b0;
        setIdle();
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        applyReset();

        setIdle();
        dis_valid = 2'b11; dis_dest[0] = 3; dis_pr_new[0] = 40;
        dis_dest[1] = 12; dis_pr_new[1] = 41; dis_src1[1] = 3;
        applyStimulus();

        setIdle();
        cdb_valid = 2'b01; cdb_tag[0] = 40; dis_src1[0] = 3; dis_src2[1] = 3;
        applyStimulus();
        setIdle();
        dis_src1[0] = 3;
        applyStimulus();

`ifdef MAP_TABLE_CKPT_EN
        setIdle();
        dis_valid = 2'b01; dis_dest[0] = 9; dis_pr_new[0] = 20; dis_br = 2'b01;
        applyStimulus();
        setIdle();
        dis_valid = 2'b01; dis_dest[0] = 7; dis_pr_new[0] = 50;
        applyStimulus();
        setIdle();
        dis_valid = 2'b01; dis_dest[0] = 7; dis_pr_new[0] = 51;
        br_valid = 1'b1; br_id = 0; br_mispred = 1'b1; dis_src1[0] = 7;
        applyStimulus();
        setIdle();
        dis_src1[0] = 7;
        applyStimulus();

        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < NC; a++) begin
                setIdle();
                dis_valid = 2'b01; dis_dest[0] = AB'($urandom_range(1, NR-1)); dis_br = 2'b01;
                applyStimulus();
            end
            setIdle();
            applyStimulus();
            if (r == 0) applyReset();
        end
        setIdle();
        br_valid = 1'b1; br_id = 0; br_mispred = 1'b0;
        applyStimulus();
        setIdle();
        applyStimulus();
`endif

        setIdle();
        dis_valid = 2'b01; dis_dest[0] = 0; dis_pr_new[0] = 33;
        applyStimulus();
        setIdle();
        dis_src1[0] = 0; dis_src2[1] = 0;
        applyStimulus();

        for (int v = 0; v < 600; v++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset();
            end else begin
                genRandom();
                applyStimulus();
            end
        end

        setIdle();
        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/map_table_ckpt.md
MAP_TABLE_CKPT -- requirements
Module: map_table_ckpt

Interface
REQ-001 Parameter N_WAY, 2, dispatch/complete width.
REQ-002 Parameter ARCH_REGS, 32, architectural register count; AREG_BITS = clog2.
REQ-003 Parameter PREG_BITS, 6, physical tag width.
REQ-004 Parameter N_CKPT, 4, checkpoint slots; CKPT_BITS = clog2.
REQ-005 clock  in  1  single clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 dis_valid  in  N_WAY  per-way dispatch valid.
REQ-008 dis_dest / dis_src1 / dis_src2  in  N_WAY x AREG_BITS  architectural indices.
REQ-009 dis_pr_new  in  N_WAY x PREG_BITS  free-list tag per way.
REQ-010 dis_br  in  N_WAY  way is a branch needing a checkpoint.
REQ-011 cdb_valid  in  N_WAY; cdb_tag  in  N_WAY x PREG_BITS  completion broadcast.
REQ-012 src1_out / src2_out  out  N_WAY x PR_PACKET  {phy_reg, status}, combinational.
REQ-013 told_out  out  N_WAY x PREG_BITS  prior mapping of dis_dest, for the ROB.
REQ-014 ckpt_id  out  CKPT_BITS  slot allocated this cycle; ckpt_full  out  1  dispatch stall.
REQ-015 br_valid  in  1; br_id  in  CKPT_BITS; br_mispred  in  1  branch resolution.

Function
REQ-016 Rename: valid way with dis_dest!=0 SHALL write {dis_pr_new, status 0} at clock edge; dest 0 SHALL never be remapped.
REQ-017 Intra-bundle: way n source matching dest of valid way k<n (dest!=0) SHALL return {dis_pr_new[k], 0}; highest such k wins; told_out[n] likewise returns dis_pr_new[k].
REQ-018 Same-cycle same-dest writes: highest way wins.
REQ-019 Completion: every entry with phy_reg == a valid cdb_tag SHALL set status 1 next edge, parallel compare, no search.
REQ-020 CDB bypass: source lookup whose phy_reg matches a valid cdb_tag this cycle SHALL return status 1 (not applied to intra-bundle forwards).
REQ-021 Rename and CDB hitting same entry same cycle: rename wins (status 0).
REQ-022 Checkpoint: at most one dis_br per cycle, always the last valid way; snapshot = table after whole bundle applied, stored at tail slot; ckpt_id = tail.
REQ-023 Stored checkpoints SHALL also receive REQ-019 status updates.
REQ-024 Slots form a circular buffer (head, tail, count); ckpt_full = (count == N_CKPT); dispatch with dis_br while full is illegal (asserted in sim).
REQ-025 Correct resolve (br_valid, !br_mispred): clear slot br_id valid; head SHALL advance over at most one invalid slot per cycle.
REQ-026 Mispredict: table <= slot br_id contents plus this cycle's CDB updates; tail <= br_id+1; slots younger than br_id freed; count recomputed; same-cycle dispatch ignored.
REQ-027 Pointers wrap modulo N_CKPT.

Reset
REQ-028 reset_n low: entry i = {phy i, status 1}; head=tail=count=0; all slots invalid; ckpt_full=0.
REQ-029 Reset mid-operation SHALL discard all in-flight checkpoints immediately, without waiting for clock.

Configuration
REQ-030 MAP_TABLE_CKPT_EN defined: REQ-022..027 active.
REQ-031 Undefined: no checkpoint storage; ckpt_full=0, ckpt_id=0; dis_br and br_* ignored; REQ-016..021 unchanged.

Structure
REQ-032 Package map_pkg SHALL hold PR_PACKET and default parameter values.
REQ-033 Sub-module map_ckpt_ctrl SHALL own head/tail/count/valid and full logic.

Verification
REQ-034 Reset, read src1=5 -> {phy 5, status 1}.
REQ-035 Way0 dest 3 new 40, way1 src1 3 -> src1_out[1]={40,0}; told_out[0]=3.
REQ-036 Map r3->40 pending; cdb_tag=40 with lookup of r3 -> status 1 same cycle; next cycle stored status 1.
REQ-037 Branch with ckpt 0, then r7->50; mispredict br_id 0 -> r7 reads {7,1}; count=0.
REQ-038 Allocate N_CKPT checkpoints -> ckpt_full=1; resolve slot 0 correct -> next cycle ckpt_full=0.
REQ-039 Dispatch dest 0 new 33 -> src r0 still {0,1}.
